// File: rtl/hub75_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_seq
// Description : HUB75 row scan sequencer. Walks the panel rows in LINEAR,
//               ZIGZAG or BITREV order, prefetches each row into the back
//               buffer, swaps it to the front and launches one or more BCM
//               passes per row.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_seq #(
    parameter int N_FB       = 2,
    parameter int N_ROWS     = 32,
    parameter     SCAN_MODE  = "ZIGZAG",
    parameter int LOG_N_FB   = $clog2(N_FB),
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_run,
    output logic                  ctrl_rdy,
    input  logic [LOG_N_FB-1:0]   frame_req,
    output logic [LOG_N_FB-1:0]   frame_cur,
    output logic                  frame_start,
    input  logic [2:0]            cfg_row_repeat,
    output logic [LOG_N_ROWS-1:0] fb_row_addr,
    output logic                  fb_row_load,
    input  logic                  fb_row_rdy,
    output logic                  fb_row_swap,
    output logic [LOG_N_ROWS-1:0] bcm_row,
    output logic                  bcm_row_first,
    output logic                  bcm_go,
    input  logic                  bcm_rdy
);

    // Row order selector: 0 = linear, 1 = zigzag, 2 = bit-reversed
    localparam int MODE_SEL = (SCAN_MODE == "LINEAR") ? 0 :
                              (SCAN_MODE == "BITREV") ? 2 : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_WAIT_PF  = 3'd2;
    localparam logic [2:0] S_SWAP     = 3'd3;
    localparam logic [2:0] S_GO       = 3'd4;
    localparam logic [2:0] S_WAIT_BCM = 3'd5;

    logic [2:0]            state;
    logic [LOG_N_ROWS-1:0] row_idx;
    logic [2:0]            rep_cnt;
    logic [LOG_N_ROWS-1:0] next_idx;
    logic                  last_row;
    logic                  prefetch;

    // Logical row index to physical row address
    function automatic logic [LOG_N_ROWS-1:0] phys(input logic [LOG_N_ROWS-1:0] idx);
        logic [LOG_N_ROWS-1:0] r;
        r = idx;
        if (MODE_SEL == 1) begin
            // Even rows fill the top half, odd rows the bottom half: a
            // rotate-right by one bit of the logical index.
            r = {idx[0], idx[LOG_N_ROWS-1:1]};
        end else if (MODE_SEL == 2) begin
            for (int b = 0; b < LOG_N_ROWS; b++) begin
                r[b] = idx[LOG_N_ROWS-1-b];
            end
        end
        return r;
    endfunction

    assign next_idx = row_idx + LOG_N_ROWS'(1);
    assign last_row = (row_idx == LOG_N_ROWS'(N_ROWS - 1));
    // The next row is fetched during the first pass of the current row
    assign prefetch = (state == S_GO) && (rep_cnt == 3'd0) && !last_row;

    // Outputs decoded from the registered state so reset clears them at once
    always_comb begin
        ctrl_rdy      = (state == S_IDLE);
        frame_start   = (state == S_LOAD);
        fb_row_load   = (state == S_LOAD) || prefetch;
        fb_row_addr   = prefetch ? phys(next_idx) : phys(row_idx);
        fb_row_swap   = (state == S_SWAP);
        bcm_go        = (state == S_GO);
        bcm_row_first = (state == S_GO) && (row_idx == '0) && (rep_cnt == 3'd0);
    end

    // Scan state machine with row / repeat counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            row_idx   <= '0;
            rep_cnt   <= 3'd0;
            frame_cur <= '0;
            bcm_row   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl_run) begin
                        frame_cur <= frame_req;
                        row_idx   <= '0;
                        rep_cnt   <= 3'd0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_WAIT_PF;
                end
                S_WAIT_PF: begin
                    if (fb_row_rdy && bcm_rdy) begin
                        state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    bcm_row <= phys(row_idx);
                    state   <= S_GO;
                end
                S_GO: begin
                    state <= S_WAIT_BCM;
                end
                S_WAIT_BCM: begin
                    if (bcm_rdy) begin
                        if (rep_cnt < cfg_row_repeat) begin
                            rep_cnt <= rep_cnt + 3'd1;
                            state   <= S_GO;
                        end else begin
                            rep_cnt <= 3'd0;
                            if (last_row) begin
                                state <= S_IDLE;
                            end else begin
                                row_idx <= next_idx;
                                state   <= S_WAIT_PF;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_scan_seq
// Description : Bench for hub75_scan_seq. Three instances (4-row LINEAR,
//               8-row ZIGZAG, 8-row BITREV) with latency responders, a frame
//               monitor and table-driven frame checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       run     [3];
    logic       freq    [3];
    logic [2:0] rrep    [3];
    logic       fb_rdy  [3];
    logic       bcm_rdy [3];

    logic       rdy    [3];
    logic       fstart [3];
    logic       load   [3];
    logic       swap   [3];
    logic       go     [3];
    logic       first  [3];
    logic       fcur   [3];
    logic [2:0] addr   [3];
    logic [2:0] brow   [3];

    // Expectations written by the test, read by the monitor
    logic [31:0] exp_seq  [3];
    int          exp_rep  [3];
    logic        exp_fcur [3];
    int          lat_mode [3];

    // Monitor results
    int          ld_cnt    [3];
    int          sw_cnt    [3];
    int          go_cnt    [3];
    int          first_cnt [3];
    int          fs_tot    [3];
    int          viol      [3];
    logic [31:0] ld_seq    [3];
    logic        p_ld [3], p_sw [3], p_go [3], p_fs [3], p_fcur [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int          NR   = (k == 0) ? 4 : 8;
        localparam int          LW   = (k == 0) ? 2 : 3;
        localparam logic [47:0] MODE = (k == 0) ? "LINEAR" : (k == 1) ? "ZIGZAG" : "BITREV";
        logic [LW-1:0] a;
        logic [LW-1:0] r;
        logic [0:0]    fc;
        hub75_scan_seq #(.N_FB(2), .N_ROWS(NR), .SCAN_MODE(MODE)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .ctrl_run       (run[k]),
            .ctrl_rdy       (rdy[k]),
            .frame_req      (freq[k]),
            .frame_cur      (fc),
            .frame_start    (fstart[k]),
            .cfg_row_repeat (rrep[k]),
            .fb_row_addr    (a),
            .fb_row_load    (load[k]),
            .fb_row_rdy     (fb_rdy[k]),
            .fb_row_swap    (swap[k]),
            .bcm_row        (r),
            .bcm_row_first  (first[k]),
            .bcm_go         (go[k]),
            .bcm_rdy        (bcm_rdy[k])
        );
        assign addr[k] = 3'(a);
        assign brow[k] = 3'(r);
        assign fcur[k] = fc[0];
    end

    function automatic int nrows(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Back-buffer and BCM engine models: busy for a latency after each request
    int fb_cnt [3];
    int bc_cnt [3];
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                fb_rdy[k]  <= 1'b1;
                bcm_rdy[k] <= 1'b1;
                fb_cnt[k]  <= 0;
                bc_cnt[k]  <= 0;
            end else begin
                if (load[k]) begin
                    fb_rdy[k] <= 1'b0;
                    fb_cnt[k] <= (lat_mode[k] == 0) ? int'($urandom_range(1, 5)) : lat_mode[k];
                end else if (fb_cnt[k] > 0) begin
                    fb_cnt[k] <= fb_cnt[k] - 1;
                    if (fb_cnt[k] == 1) fb_rdy[k] <= 1'b1;
                end
                if (go[k]) begin
                    bcm_rdy[k] <= 1'b0;
                    bc_cnt[k]  <= (lat_mode[k] == 0) ? int'($urandom_range(1, 5)) : lat_mode[k];
                end else if (bc_cnt[k] > 0) begin
                    bc_cnt[k] <= bc_cnt[k] - 1;
                    if (bc_cnt[k] == 1) bcm_rdy[k] <= 1'b1;
                end
            end
        end
    end

    // Frame monitor: per-frame event counts plus protocol rule violations
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int          lb, sb, gb, fb, v, idx;
            logic [31:0] s;
            if (rst) begin
                p_ld[k] <= 1'b0; p_sw[k] <= 1'b0; p_go[k] <= 1'b0; p_fs[k] <= 1'b0;
                p_fcur[k] <= fcur[k];
            end else begin
                v  = 0;
                lb = fstart[k] ? 0 : ld_cnt[k];
                sb = fstart[k] ? 0 : sw_cnt[k];
                gb = fstart[k] ? 0 : go_cnt[k];
                fb = fstart[k] ? 0 : first_cnt[k];
                s  = fstart[k] ? 32'h0 : ld_seq[k];
                if (fstart[k] && fcur[k] != exp_fcur[k]) v++;
                if (!fstart[k] && fcur[k] != p_fcur[k]) v++;
                if (load[k] && lb < 8) s[lb*4 +: 4] = {1'b0, addr[k]};
                if (go[k]) begin
                    if (!bcm_rdy[k]) v++;
                    idx = gb / (exp_rep[k] + 1);
                    if (idx > 7 || brow[k] != exp_seq[k][idx*4 +: 3]) v++;
                    if (first[k] != (gb == 0)) v++;
                end
                if (first[k] && !go[k]) v++;
                if ((load[k] && p_ld[k]) || (swap[k] && p_sw[k]) ||
                    (go[k] && p_go[k]) || (fstart[k] && p_fs[k])) v++;
                if (v != 0) $display("monitor dut%0d: %0d rule violation(s) at %0t", k, v, $time);
                viol[k]      <= viol[k] + v;
                ld_cnt[k]    <= lb + int'(load[k]);
                sw_cnt[k]    <= sb + int'(swap[k]);
                go_cnt[k]    <= gb + int'(go[k]);
                first_cnt[k] <= fb + int'(first[k]);
                fs_tot[k]    <= fs_tot[k] + int'(fstart[k]);
                ld_seq[k]    <= s;
                p_ld[k] <= load[k]; p_sw[k] <= swap[k]; p_go[k] <= go[k]; p_fs[k] <= fstart[k];
                p_fcur[k] <= fcur[k];
            end
        end
    end

    task automatic setup(input int k, input int rep, input int fr, input logic [31:0] seq, input int lat);
        exp_seq[k]  = seq;
        exp_rep[k]  = rep;
        exp_fcur[k] = fr[0];
        lat_mode[k] = lat;
        rrep[k]     = 3'(rep);
        freq[k]     = fr[0];
    endtask

    task automatic wait_start(input int k, input string name);
        bit seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (fstart[k]) seen = 1;
        end
        chk(name, int'(seen), 1);
    endtask

    task automatic wait_idle(input int k, input string name);
        bit seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (rdy[k]) seen = 1;
        end
        chk(name, int'(seen), 1);
    endtask

    // Expected per-frame totals come from the row count and repeat setting
    task automatic check_frame(input int k, input int rep, input logic [31:0] seq, input int v0, input string tag);
        int n = nrows(k);
        chk({tag, " loads"},    ld_cnt[k], n);
        chk({tag, " addr_seq"}, int'(ld_seq[k]), int'(seq));
        chk({tag, " swaps"},    sw_cnt[k], n);
        chk({tag, " gos"},      go_cnt[k], n * (rep + 1));
        chk({tag, " firsts"},   first_cnt[k], 1);
        chk({tag, " rules"},    viol[k] - v0, 0);
    endtask

    task automatic run_frame(input int k, input int rep, input int fr, input logic [31:0] seq,
                             input int lat, input bit drop, input string tag);
        int v0, f0;
        setup(k, rep, fr, seq, lat);
        @(negedge clk);
        v0 = viol[k];
        f0 = fs_tot[k];
        run[k] = 1'b1;
        wait_start(k, {tag, " frame_start"});
        freq[k] = ~fr[0];
        if (drop) begin
            repeat (5) @(negedge clk);
            run[k] = 1'b0;
        end
        wait_idle(k, {tag, " ctrl_rdy"});
        run[k] = 1'b0;
        repeat (3) @(negedge clk);
        check_frame(k, rep, seq, v0, tag);
        chk({tag, " one_frame"}, fs_tot[k] - f0, 1);
        chk({tag, " frame_cur"}, int'(fcur[k]), fr);
    endtask

    typedef struct {
        int          k;
        int          rep;
        int          fr;
        logic [31:0] seq;
        int          lat;
        bit          drop;
    } vec_t;

    vec_t tbl [7];

    initial begin
        for (int k = 0; k < 3; k++) begin
            run[k] = 1'b0; freq[k] = 1'b0; rrep[k] = 3'd0;
            exp_seq[k] = 32'h0; exp_rep[k] = 0; exp_fcur[k] = 1'b0; lat_mode[k] = 3;
            viol[k] = 0; fs_tot[k] = 0;
        end
        // {dut, repeat, frame_req, fb_row_addr sequence (nibble 0 first), latency, drop run}
        tbl[0] = '{0, 0, 0, 32'h0000_3210, 3, 1'b0};
        tbl[1] = '{1, 0, 1, 32'h7362_5140, 0, 1'b0};
        tbl[2] = '{2, 0, 0, 32'h7351_6240, 0, 1'b0};
        tbl[3] = '{0, 2, 1, 32'h0000_3210, 0, 1'b0};
        tbl[4] = '{1, 1, 0, 32'h7362_5140, 0, 1'b1};
        tbl[5] = '{2, int'($urandom_range(0, 7)), 1, 32'h7351_6240, 0, 1'b0};
        tbl[6] = '{0, int'($urandom_range(0, 7)), 1, 32'h0000_3210, 0, 1'b1};

        // Reset state
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst ctrl_rdy", int'(rdy[k]), 1);
            chk("rst pulses", int'({fstart[k], load[k], swap[k], go[k], first[k]}), 0);
            chk("rst regs", int'({addr[k], brow[k], fcur[k]}), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_frame(tbl[t].k, tbl[t].rep, tbl[t].fr, tbl[t].seq, tbl[t].lat, tbl[t].drop,
                      $sformatf("vec%0d", t));
        end

        // Back-to-back frames: frame_start one cycle after IDLE is re-entered
        setup(0, 0, 1, 32'h0000_3210, 1);
        @(negedge clk);
        run[0] = 1'b1;
        wait_start(0, "b2b frame_start");
        wait_idle(0, "b2b idle");
        @(negedge clk);
        chk("b2b restart", int'(fstart[0]), 1);
        run[0] = 1'b0;
        wait_idle(0, "b2b second idle");
        repeat (2) @(negedge clk);
        chk("b2b second frame loads", ld_cnt[0], 4);

        // Asynchronous reset while waiting on the BCM engine
        setup(1, 0, 1, 32'h7362_5140, 4);
        @(negedge clk);
        run[1] = 1'b1;
        wait_start(1, "arst frame_start");
        begin
            bit seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                if (go[1] && brow[1] != 3'd0) seen = 1;
            end
            chk("arst reach row1 go", int'(seen), 1);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst ctrl_rdy", int'(rdy[1]), 1);
        chk("arst pulses", int'({fstart[1], load[1], swap[1], go[1], first[1]}), 0);
        chk("arst bcm_row", int'(brow[1]), 0);
        chk("arst frame_cur", int'(fcur[1]), 0);
        chk("arst addr", int'(addr[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_start(1, "arst restart");
        chk("arst restart addr", int'(addr[1]), 0);
        chk("arst restart load", int'(load[1]), 1);
        run[1] = 1'b0;
        wait_idle(1, "arst idle");
        repeat (2) @(negedge clk);
        check_frame(1, 0, 32'h7362_5140, viol[1], "arst frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
